// File: rtl/funprof_pkg.sv
// rtl/funprof_pkg.sv - shared widths and frame/record types for the function profiler call stack
package funprof_pkg;

    localparam int FP_ADDR_W = 32;
    localparam int FP_CNT_W  = 32;
    localparam int FP_DEPTH  = 16;
    localparam int FP_DEP_W  = 5;

    typedef struct packed {
        logic [FP_ADDR_W-1:0] addr;
        logic [FP_CNT_W-1:0]  ts;
    } frame_t;

    typedef struct packed {
        logic [FP_ADDR_W-1:0] addr;
        logic [FP_CNT_W-1:0]  cycles;
        logic [FP_DEP_W-1:0]  depth;
    } record_t;

endpackage

// File: rtl/funprof_lifo.sv
// rtl/funprof_lifo.sv - register-file LIFO with same-cycle push+pop replacing the top entry
module funprof_lifo #(
    parameter int W     = 64,
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     top,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign top_idx = IDX_W'(count - CNT_W'(1));
    assign wr_idx  = IDX_W'(count);
    assign top     = mem[top_idx];

    // a pop frees a slot, so a push is still legal when full if it pairs with a pop
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // storage write: paired push+pop overwrites the top, lone push appends
    always_ff @(posedge clk) begin
        if (do_push && do_pop) begin
            mem[top_idx] <= din;
        end else if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

    // occupancy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (do_push && !do_pop) begin
            count <= count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/funprof_callstack.sv
// rtl/funprof_callstack.sv - shadow call stack turning call/ret pulses into per-function timing records
module funprof_callstack
    import funprof_pkg::*;
#(
    parameter int ADDR_W = FP_ADDR_W,
    parameter int CNT_W  = FP_CNT_W,
    parameter int DEPTH  = FP_DEPTH,
    parameter int DEP_W  = FP_DEP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target_addr,
    input  logic              clr_flags,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [ADDR_W-1:0] rec_addr,
    output logic [CNT_W-1:0]  rec_cycles,
    output logic [DEP_W-1:0]  rec_depth,
    output logic [DEP_W-1:0]  depth,
    output logic              overflow,
    output logic              underflow,
    output logic              rec_lost
);

    logic [CNT_W-1:0] ts;
    logic [DEP_W-1:0] miss_cnt;
    logic [DEP_W-1:0] miss_nxt;
    frame_t           push_frame;
    frame_t           top_frame;
    record_t          new_record;
    record_t          rec_q;
    logic             full;
    logic             empty;
    logic             do_pop;
    logic             do_push;
    logic             ovf_set;
    logic             unf_set;
    logic             lost_set;

    // a ret while frames are missing belongs to a call that was never pushed
    assign do_pop   = ret && (miss_cnt == '0) && !empty;
    assign unf_set  = ret && (miss_cnt == '0) && empty;
    assign do_push  = call && (!full || do_pop);
    assign ovf_set  = call && full && !do_pop;
    assign lost_set = do_pop && rec_valid && !rec_ready;

    assign push_frame.addr   = target_addr;
    assign push_frame.ts     = ts;
    assign new_record.addr   = top_frame.addr;
    assign new_record.cycles = ts - top_frame.ts;
    assign new_record.depth  = depth;

    funprof_lifo #(
        .W     ($bits(frame_t)),
        .DEPTH (DEPTH),
        .CNT_W (DEP_W)
    ) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (do_pop),
        .din   (push_frame),
        .top   (top_frame),
        .full  (full),
        .empty (empty),
        .count (depth)
    );

    // free-running timestamp
    always_ff @(posedge clk) begin
        if (rst) begin
            ts <= '0;
        end else begin
            ts <= ts + CNT_W'(1);
        end
    end

    // ret is applied before call, so a same-cycle drop and absorb cancel out
    always_comb begin
        miss_nxt = miss_cnt;
        if (ret && (miss_cnt != '0)) begin
            miss_nxt = miss_nxt - DEP_W'(1);
        end
        if (ovf_set && (miss_nxt != '1)) begin
            miss_nxt = miss_nxt + DEP_W'(1);
        end
    end

    // dropped-frame counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt <= '0;
        end else begin
            miss_cnt <= miss_nxt;
        end
    end

    // single-entry output register; a held, unaccepted record is never overwritten
    always_ff @(posedge clk) begin
        if (rst) begin
            rec_valid <= 1'b0;
            rec_q     <= '0;
        end else if (do_pop && !(rec_valid && !rec_ready)) begin
            rec_valid <= 1'b1;
            rec_q     <= new_record;
        end else if (rec_ready) begin
            rec_valid <= 1'b0;
        end
    end

    assign rec_addr   = rec_q.addr;
    assign rec_cycles = rec_q.cycles;
    assign rec_depth  = rec_q.depth;

    // sticky error flags; a set event outranks a clear in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rec_lost  <= 1'b0;
        end else begin
            overflow  <= ovf_set  ? 1'b1 : (clr_flags ? 1'b0 : overflow);
            underflow <= unf_set  ? 1'b1 : (clr_flags ? 1'b0 : underflow);
            rec_lost  <= lost_set ? 1'b1 : (clr_flags ? 1'b0 : rec_lost);
        end
    end

endmodule

// File: tb/tb_funprof_callstack.sv
// tb/tb_funprof_callstack.sv - self-checking bench for funprof_callstack
module tb_funprof_callstack;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        call;
    logic        ret;
    logic [31:0] target_addr;
    logic        clr_flags;
    logic        rec_valid;
    logic        rec_ready;
    logic [31:0] rec_addr;
    logic [31:0] rec_cycles;
    logic [4:0]  rec_depth;
    logic [4:0]  depth;
    logic        overflow;
    logic        underflow;
    logic        rec_lost;

    funprof_callstack dut (
        .clk         (clk),
        .rst         (rst),
        .call        (call),
        .ret         (ret),
        .target_addr (target_addr),
        .clr_flags   (clr_flags),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec_addr    (rec_addr),
        .rec_cycles  (rec_cycles),
        .rec_depth   (rec_depth),
        .depth       (depth),
        .overflow    (overflow),
        .underflow   (underflow),
        .rec_lost    (rec_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        call;
        logic        ret;
        logic [31:0] addr;
        logic        ready;
        logic        clr;
        logic [4:0]  exp_depth;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ts;
    } mframe_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] cycles;
        int          depth;
    } mrec_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_xfer = 0;
    logic [31:0] m_ts;
    mframe_t     m_stk[$];
    mrec_t       sb[$];
    int          m_miss;
    bit          m_valid, m_ovf, m_unf, m_lost;
    vec_t        vecs[44];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; call = 1'b1; ret = 1'b1; target_addr = 32'hdead_beef;
        rec_ready = 1'b0; clr_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; call = 1'b0; ret = 1'b0;
        m_ts = 0; m_stk.delete(); sb.delete(); m_miss = 0;
        m_valid = 0; m_ovf = 0; m_unf = 0; m_lost = 0;
        chk("rst_rec_valid", rec_valid, 0);
        chk("rst_rec_addr", rec_addr, 0);
        chk("rst_rec_cycles", rec_cycles, 0);
        chk("rst_rec_depth", rec_depth, 0);
        chk("rst_depth", depth, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_rec_lost", rec_lost, 0);
    endtask

    task automatic cycle(input logic c, input logic r, input logic [31:0] a,
                         input logic rdy, input logic clr);
        mrec_t   e, nr;
        mframe_t f;
        bit      new_r = 0, ovf_set = 0, unf_set = 0, lost_set = 0;
        call = c; ret = r; target_addr = a; rec_ready = rdy; clr_flags = clr;
        if (m_valid && rdy) begin
            if (sb.size() == 0) begin
                chk("sb_underrun", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("xfer_addr", rec_addr, e.addr);
                chk("xfer_cycles", rec_cycles, e.cycles);
                chk("xfer_depth", rec_depth, e.depth);
                n_xfer++;
            end
        end
        if (r) begin
            if (m_miss > 0) begin
                m_miss--;
            end else if (m_stk.size() > 0) begin
                nr.depth = m_stk.size();
                f = m_stk.pop_back();
                nr.addr = f.addr;
                nr.cycles = m_ts - f.ts;
                new_r = 1;
            end else begin
                unf_set = 1;
            end
        end
        if (c) begin
            if (m_stk.size() < DEPTH) begin
                f.addr = a; f.ts = m_ts;
                m_stk.push_back(f);
            end else begin
                ovf_set = 1;
                if (m_miss < 31) m_miss++;
            end
        end
        if (new_r) begin
            if (m_valid && !rdy) lost_set = 1;
            else begin m_valid = 1; sb.push_back(nr); end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_ovf  = ovf_set  ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf  = unf_set  ? 1'b1 : (clr ? 1'b0 : m_unf);
        m_lost = lost_set ? 1'b1 : (clr ? 1'b0 : m_lost);
        m_ts++;
        @(posedge clk);
        #1;
        chk("depth", depth, m_stk.size());
        chk("rec_valid", rec_valid, m_valid);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
        chk("rec_lost", rec_lost, m_lost);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 1'b0, 32'h0, rdy, 1'b0);
    endtask

    int base;

    initial begin
        clk = 1'b0; rst = 1'b1; call = 1'b0; ret = 1'b0; target_addr = '0;
        clr_flags = 1'b0; rec_ready = 1'b0;

        for (int i = 0; i < 44; i++) begin
            vecs[i] = '{call: 1'b0, ret: 1'b0, addr: 32'h0, ready: 1'b1, clr: 1'b0, exp_depth: 5'd0};
        end
        vecs[5].call = 1'b1;  vecs[5].addr = 32'h0000_1000;
        vecs[15].ret = 1'b1;
        vecs[20].call = 1'b1; vecs[20].addr = 32'h100;
        vecs[23].call = 1'b1; vecs[23].addr = 32'h200;
        vecs[28].ret = 1'b1;
        vecs[40].ret = 1'b1;
        for (int i = 5; i < 15; i++) vecs[i].exp_depth = 5'd1;
        for (int i = 20; i < 23; i++) vecs[i].exp_depth = 5'd1;
        for (int i = 23; i < 28; i++) vecs[i].exp_depth = 5'd2;
        for (int i = 28; i < 40; i++) vecs[i].exp_depth = 5'd1;

        do_reset();

        for (int i = 0; i < 44; i++) begin
            cycle(vecs[i].call, vecs[i].ret, vecs[i].addr, vecs[i].ready, vecs[i].clr);
            chk("tbl_depth", depth, vecs[i].exp_depth);
            if (i == 15 || i == 28 || i == 40) begin
                chk("tbl_rec_valid", rec_valid, 1);
                chk("tbl_rec_addr", rec_addr, (i == 15) ? 32'h1000 : (i == 28) ? 32'h200 : 32'h100);
                chk("tbl_rec_cycles", rec_cycles, (i == 15) ? 10 : (i == 28) ? 5 : 20);
                chk("tbl_rec_depth", rec_depth, (i == 28) ? 2 : 1);
            end
        end

        base = n_xfer;
        for (int k = 0; k < DEPTH + 2; k++) cycle(1'b1, 1'b0, 32'h4000 + k, 1'b1, 1'b0);
        chk("ovf_depth_full", depth, DEPTH);
        for (int k = 0; k < DEPTH + 2; k++) cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        idle(1'b1); idle(1'b1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_no_underflow", underflow, 0);
        chk("ovf_record_count", n_xfer - base, DEPTH);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("ovf_cleared", overflow, 0);

        cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        chk("unf_flag", underflow, 1);
        chk("unf_no_record", rec_valid, 0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("unf_cleared", underflow, 0);

        cycle(1'b1, 1'b0, 32'h500, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h600, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        chk("bp_lost", rec_lost, 1);
        chk("bp_held_addr", rec_addr, 32'h600);
        idle(1'b0);
        chk("bp_still_held", rec_addr, 32'h600);
        base = n_xfer;
        repeat (3) idle(1'b1);
        chk("bp_one_transfer", n_xfer - base, 1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("bp_lost_cleared", rec_lost, 0);

        for (int k = 0; k < DEPTH; k++) cycle(1'b1, 1'b0, 32'h7000 + k, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 32'h7777, 1'b1, 1'b0);
        chk("sim_depth", depth, DEPTH);
        chk("sim_no_overflow", overflow, 0);
        chk("sim_rec_addr", rec_addr, 32'h700F);
        chk("sim_rec_depth", rec_depth, DEPTH);
        idle(1'b1);
        cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        chk("sim_pushed_frame", rec_addr, 32'h7777);
        cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);

        do_reset();
        idle(1'b1); idle(1'b1);
        cycle(1'b1, 1'b0, 32'hABC, 1'b1, 1'b0);
        repeat (6) idle(1'b1);
        cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        chk("post_rst_addr", rec_addr, 32'hABC);
        chk("post_rst_cycles", rec_cycles, 7);
        idle(1'b1); idle(1'b1);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/funprof_callstack.md
Name: funprof_callstack

Overview:
- Consumer side of the call/return decoder in the function profiler.
- Takes single-cycle call/ret event pulses plus the call target address, and keeps a shadow call stack of (function address, entry timestamp).
- On each return, emits one record (function address, elapsed cycles, nesting depth) through a valid/ready handshake to the profiler's record buffer.

Parameters:
- ADDR_W, 32, width of function target address
- CNT_W, 32, width of free-running timestamp and elapsed-cycle field
- DEPTH, 16, shadow stack entries (power of 2)
- DEP_W, 5, width of depth fields (must hold 0..DEPTH)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- call  in  1  call event pulse, one cycle per decoded call
- ret  in  1  return event pulse, one cycle per decoded return
- target_addr  in  ADDR_W  call target, sampled only when call=1
- clr_flags  in  1  clears sticky error flags
- rec_valid  out  1  record available
- rec_ready  in  1  downstream accepts record
- rec_addr  out  ADDR_W  function address of returning frame
- rec_cycles  out  CNT_W  elapsed cycles, call to ret
- rec_depth  out  DEP_W  stack depth of the frame (1 = outermost)
- depth  out  DEP_W  current valid stack occupancy
- overflow  out  1  sticky: a call arrived while stack full
- underflow  out  1  sticky: a ret arrived with no open frame
- rec_lost  out  1  sticky: record dropped because output was occupied

Behaviour:
- Reset: all outputs 0. Stack empty, timestamp 0, miss counter 0. Reset mid-operation discards all frames and any pending record.
- Timestamp: free-running CNT_W counter, increments every cycle, wraps. Elapsed time is ts_ret - ts_call, modulo 2^CNT_W. Example: call sampled at ts=N, ret sampled at ts=N+10 gives rec_cycles=10.
- Call, stack not full: push {target_addr, ts}; depth+1 on the next cycle.
- Call, stack full: nothing is pushed and overflow is set. miss_cnt increments, saturating at 2^DEP_W-1.
- Ret with miss_cnt>0: miss_cnt decrements. No pop and no record; this absorbs the return of a dropped frame.
- Ret with miss_cnt=0 and depth>0: pop the top frame. The record is registered and rec_valid is asserted on the cycle after ret (latency 1).
  - rec_depth is the depth before the pop.
- Ret with miss_cnt=0 and depth=0: underflow is set, no record.
- Output register holds a single entry:
  - Record held until rec_valid && rec_ready.
  - A new record on the acceptance cycle overwrites it, so back-to-back records are possible.
  - If rec_valid=1 and rec_ready=0 when a new record is produced, the new record is dropped, rec_lost is set, and the held record is unchanged.
- Simultaneous call and ret in one cycle: ret is processed first (pop/record), then call pushes into the freed slot. Depth is unchanged; overflow cannot occur in this case when the stack was full.
- Sticky flags clear on clr_flags=1. A set event in the same cycle wins.
- call/ret are ignored during rst.

Decomposition:
- Shared package funprof_pkg holds:
  - ADDR_W/CNT_W/DEPTH defaults
  - record struct {addr, cycles, depth}
  - frame struct {addr, ts}
- Sub-module funprof_lifo: DEPTH-entry register-file stack.
  - Inputs: push, pop, din.
  - Outputs: top, full, empty, count.
  - Supports push+pop in the same cycle (replace top).
- funprof_callstack owns:
  - timestamp counter
  - miss counter
  - output register/handshake
  - sticky flags

Test Plan:
- Single frame: call target 0x0000_1000 at cycle 5, ret at cycle 15, rec_ready=1 → rec_valid at cycle 16 with addr=0x1000, cycles=10, depth=1; depth returns to 0.
- Nested: calls A=0x100 (t0), B=0x200 (t0+3); rets at t0+8, t0+20 → records B/5/depth 2 then A/20/depth 1, in that order.
- Overflow: DEPTH+2 calls then DEPTH+2 rets with rec_ready=1 → overflow=1; first 2 rets produce no record; then DEPTH records; underflow=0.
- Underflow and clear: ret on empty stack → underflow=1, no rec_valid; clr_flags pulse → underflow=0.
- Backpressure: rec_ready=0, two frames returned 1 cycle apart → first record held stable, rec_lost=1; raise rec_ready → one transfer only.
- Simultaneous call+ret with depth=DEPTH: top frame recorded, new frame pushed, depth=DEPTH, overflow=0. Separately, assert rst mid-sequence → depth=0, rec_valid=0, and timestamp restarts at 0.
